vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator driving VGA_HS/VGA_VS and pixel-coordinate outputs for the board's 4-bit-per-channel VGA port.
- Generalises a fixed 640x480 controller to arbitrary porch/sync/active widths, sync polarity and pixel-clock division from the 50 MHz system clock.
- Sits between the clock domain root and the pixel renderer/framebuffer reader. Supplies strobes for per-line and per-frame work.

---
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, blanking, coordinates and strobes.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_POL = 0,
    parameter int COORD_W  = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic               hs,
    output logic               vs,
    output logic               blank_n,
    output logic               pix_en,
    output logic [COORD_W-1:0] draw_x,
    output logic [COORD_W-1:0] draw_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT   = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic               SYNC_ACT = (SYNC_POL != 0);

    logic               running;
    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] hc;
    logic [COORD_W-1:0] vc;

    logic [DIV_W-1:0]   div_nxt;
    logic [COORD_W-1:0] hc_nxt;
    logic [COORD_W-1:0] vc_nxt;
    logic               pix_nxt;
    logic               hs_on;
    logic               vs_on;
    logic               blank_nxt;

    // The first edge out of reset only publishes position (0,0); counting starts after it.
    always_comb begin
        div_nxt = div_cnt;
        hc_nxt  = hc;
        vc_nxt  = vc;
        if (running) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
                if (hc == H_LAST) begin
                    hc_nxt = '0;
                    vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc_nxt = hc + 1'b1;
                end
            end else begin
                div_nxt = div_cnt + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next position so they register on the same edge as it.
    always_comb begin
        pix_nxt   = (div_nxt == DIV_LAST);
        hs_on     = (hc_nxt >= HS_BEG) && (hc_nxt <= HS_LAST);
        vs_on     = (vc_nxt >= VS_BEG) && (vc_nxt <= VS_LAST);
        blank_nxt = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            running     <= 1'b0;
            div_cnt     <= '0;
            hc          <= '0;
            vc          <= '0;
            hs          <= ~SYNC_ACT;
            vs          <= ~SYNC_ACT;
            blank_n     <= 1'b0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            div_cnt     <= div_nxt;
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            hs          <= hs_on ? SYNC_ACT : ~SYNC_ACT;
            vs          <= vs_on ? SYNC_ACT : ~SYNC_ACT;
            blank_n     <= blank_nxt;
            pix_en      <= pix_nxt;
            line_start  <= pix_nxt && (hc_nxt == '0);
            frame_start <= pix_nxt && (hc_nxt == '0) && (vc_nxt == '0);
        end
    end

    assign draw_x = hc;
    assign draw_y = vc;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [COORD_W+2:0] H_ACT_W = (COORD_W+3)'(H_ACTIVE);

    logic [2:0] bar_nxt;

    // Eight equal-width vertical bars across the visible line.
    always_comb begin
        bar_nxt = 3'({hc_nxt, 3'b000} / H_ACT_W);
    end

    always_ff @(posedge Clk) begin
        if (Reset || !blank_nxt) begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
        end else begin
            red   <= {4{bar_nxt[2]}};
            green <= {4{bar_nxt[1]}};
            blue  <= {4{bar_nxt[0]}};
        end
    end
`else
    assign red   = 4'h0;
    assign green = 4'h0;
    assign blue  = 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-horizontal instance with a short frame,
// and a tiny active-high-sync instance with CLK_DIV=1.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset;
    logic rst_s;

    always #5 Clk = ~Clk;

    // Instance A: default horizontal timing, short vertical (4/1/2/1), CLK_DIV=2.
    logic       hs, vs, blank_n, pix_en, line_start, frame_start;
    logic [9:0] draw_x, draw_y;
    logic [3:0] red, green, blue;

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(0), .COORD_W(10)
    ) dut (
        .Clk(Clk), .Reset(Reset), .hs(hs), .vs(vs), .blank_n(blank_n),
        .pix_en(pix_en), .draw_x(draw_x), .draw_y(draw_y),
        .line_start(line_start), .frame_start(frame_start),
        .red(red), .green(green), .blue(blue)
    );

    // Instance B: H=8/2/2/2, V=4/1/1/1, CLK_DIV=1, active-high sync.
    logic       hs_s, vs_s, blank_n_s, pix_en_s, line_start_s, frame_start_s;
    logic [3:0] draw_x_s, draw_y_s;
    logic [3:0] red_s, green_s, blue_s;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1), .COORD_W(4)
    ) dut_s (
        .Clk(Clk), .Reset(rst_s), .hs(hs_s), .vs(vs_s), .blank_n(blank_n_s),
        .pix_en(pix_en_s), .draw_x(draw_x_s), .draw_y(draw_y_s),
        .line_start(line_start_s), .frame_start(frame_start_s),
        .red(red_s), .green(green_s), .blue(blue_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int fs_n, fs0, fs1, ls_n, ls0, ls1, ls_frame;
    int hs_low, hs_x0, vs_low, vs_y0, vs_x0;
    int blank_seen, blank_x, blank_y, blank_bad, pix_n, hold_bad, rgb_bad;
    int prev_pix, prev_x, prev_y;
    int rgb40, rgb160, rgb600, rgb700;
    int b_pos_bad, b_sync_bad, b_strobe_bad;
    int found;

    initial begin
        Reset = 1'b1;
        rst_s = 1'b1;
        repeat (3) tick();

        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_blank_n", blank_n, 0);
        check("rst_strobes", {pix_en, line_start, frame_start}, 0);
        check("rst_pos", {draw_x, draw_y}, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_s_sync", {hs_s, vs_s}, 0);

        Reset = 1'b0;
        tick();
        check("rel_pos", {draw_x, draw_y}, 0);
        check("rel_blank_n", blank_n, 1);
        check("rel_pix_en", pix_en, 0);

        fs_n = 0; fs0 = -1; fs1 = -1; ls_n = 0; ls0 = -1; ls1 = -1; ls_frame = 0;
        hs_low = 0; hs_x0 = -1; vs_low = 0; vs_y0 = -1; vs_x0 = -1;
        blank_seen = 0; blank_x = -1; blank_y = -1; blank_bad = 0;
        pix_n = 0; hold_bad = 0; rgb_bad = 0;
        rgb40 = -1; rgb160 = -1; rgb600 = -1; rgb700 = -1;
        prev_pix = 0; prev_x = 0; prev_y = 0;

        for (int t = 0; t <= 12801; t++) begin
            if (frame_start) begin
                if (fs_n == 0) fs0 = t;
                else if (fs_n == 1) fs1 = t;
                fs_n++;
            end
            if (line_start) begin
                if (ls_n == 0) ls0 = t;
                else if (ls_n == 1) ls1 = t;
                if (t >= 1 && t <= 12800) ls_frame++;
                ls_n++;
            end
            if (t <= 12800 && draw_y == 0 && !hs) begin
                if (hs_low == 0) hs_x0 = int'(draw_x);
                hs_low++;
            end
            if (t <= 12800 && !vs) begin
                if (vs_low == 0) begin
                    vs_y0 = int'(draw_y);
                    vs_x0 = int'(draw_x);
                end
                vs_low++;
            end
            if (!blank_n && blank_seen == 0) begin
                blank_seen = 1;
                blank_x = int'(draw_x);
                blank_y = int'(draw_y);
            end
            if (draw_y >= 4 && blank_n) blank_bad++;
            if (t >= 1 && t <= 12800 && pix_en) pix_n++;
            if (t > 0) begin
                if (!prev_pix && (int'(draw_x) != prev_x || int'(draw_y) != prev_y)) hold_bad++;
                if (prev_pix && int'(draw_x) == prev_x) hold_bad++;
            end
            prev_pix = int'(pix_en);
            prev_x = int'(draw_x);
            prev_y = int'(draw_y);
            if (!blank_n && {red, green, blue} != 12'h000) rgb_bad++;
`ifdef VGA_TEST_PATTERN_EN
            if (draw_y == 0) begin
                if (draw_x == 40)  rgb40  = int'({red, green, blue});
                if (draw_x == 160) rgb160 = int'({red, green, blue});
                if (draw_x == 600) rgb600 = int'({red, green, blue});
                if (draw_x == 700) rgb700 = int'({red, green, blue});
            end
`else
            if ({red, green, blue} != 12'h000) rgb_bad++;
`endif
            tick();
        end

        check("first_frame_start", fs0, 1);
        check("frame_period", fs1 - fs0, 12800);
        check("line_period", ls1 - ls0, 1600);
        check("lines_per_frame", ls_frame, 8);
        check("hs_low_clks", hs_low, 192);
        check("hs_start_x", hs_x0, 656);
        check("blank_fall_x", blank_x, 640);
        check("blank_fall_y", blank_y, 0);
        check("vs_low_clks", vs_low, 3200);
        check("vs_start_y", vs_y0, 5);
        check("vs_start_x", vs_x0, 0);
        check("blank_vert", blank_bad, 0);
        check("pix_en_count", pix_n, 6400);
        check("pixel_hold", hold_bad, 0);
        check("rgb_blank_zero", rgb_bad, 0);
`ifdef VGA_TEST_PATTERN_EN
        check("rgb_x40", rgb40, 32'h000);
        check("rgb_x160", rgb160, 32'h0F0);
        check("rgb_x600", rgb600, 32'hFFF);
        check("rgb_x700", rgb700, 32'h000);
`endif

        // Tiny instance, one full frame plus the wrap edge.
        b_pos_bad = 0; b_sync_bad = 0; b_strobe_bad = 0;
        rst_s = 1'b0;
        tick();
        for (int t = 0; t <= 98; t++) begin
            int ex, ey;
            ex = t % 14;
            ey = (t / 14) % 7;
            if (int'(draw_x_s) != ex || int'(draw_y_s) != ey) b_pos_bad++;
            if (hs_s != (ex == 10 || ex == 11)) b_sync_bad++;
            if (vs_s != (ey == 5)) b_sync_bad++;
            if (blank_n_s != (ex < 8 && ey < 4)) b_sync_bad++;
            if (!pix_en_s) b_strobe_bad++;
            if (line_start_s != (ex == 0)) b_strobe_bad++;
            if (frame_start_s != (ex == 0 && ey == 0)) b_strobe_bad++;
            if ({red_s, green_s, blue_s} != 12'h000 && !blank_n_s) b_strobe_bad++;
            if (t == 97) check("s_last_pos", {draw_x_s, draw_y_s}, {4'd13, 4'd6});
            if (t == 98) check("s_wrap_pos", {draw_x_s, draw_y_s, frame_start_s}, 9'd1);
            tick();
        end
        check("s_position", b_pos_bad, 0);
        check("s_sync_blank", b_sync_bad, 0);
        check("s_strobes", b_strobe_bad, 0);

        // Abort a frame from inside both sync pulses.
        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            if (draw_x == 700 && draw_y == 5) found = 1;
            else tick();
        end
        check("mid_found", found, 1);
        check("mid_sync_active", {hs, vs}, 0);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_sync", {hs, vs}, 2'b11);
            check("mid_rst_blank_strobes", {blank_n, pix_en, line_start, frame_start}, 0);
            check("mid_rst_pos", {draw_x, draw_y}, 0);
        end
        Reset = 1'b0;
        tick();
        check("mid_rel_pos", {draw_x, draw_y}, 0);
        check("mid_rel_blank_fs", {blank_n, frame_start}, 2'b10);
        tick();
        check("mid_rel_frame_start", {pix_en, frame_start, draw_x}, {1'b1, 1'b1, 10'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
